// File: rtl/dac_pkg.sv
// Shared definitions for the DAC command sequencer: FSM encoding, frame layout
// and the helper that packs a queued sample into a serializer frame.
package dac_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 28;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_LSB = 16;
  localparam int CODE_LSB = 4;
  localparam int PACE_W   = 16;
  localparam int TIMEOUT_CYCLES = 4;
  localparam logic [3:0] DEFAULT_CMD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } state_t;

  // Sample is {addr[3:0], code[11:0]}; unused frame bits stay zero.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] cmd,
                                                    input logic [SAMPLE_W-1:0] sample);
    logic [FRAME_W-1:0] frame;
    frame = '0;
    frame[CMD_LSB  +: 4]  = cmd;
    frame[ADDR_LSB +: 4]  = sample[15:12];
    frame[CODE_LSB +: 12] = sample[11:0];
    return frame;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO with wrapping pointers and an occupancy count.
// Pushes while full are dropped; pops while empty are ignored.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      // Push and pop together leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_cmd_sequencer.sv
// Queues DAC samples and launches them, paced, as 28-bit frames to an SPI serializer.
// Handshake: go_DAC pulses one cycle with DAC_in valid; the serializer answers by raising trans, then dropping it when done.
module dac_cmd_sequencer
  import dac_pkg::*;
#(
  parameter logic [3:0] CMD   = DEFAULT_CMD,
  parameter int         DIV   = 50,
  parameter int         DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_Async,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic                full,
  input  logic                trans,
  output logic                go_DAC,
  output logic [FRAME_W-1:0]  DAC_in,
  output logic                busy,
  output logic                err,
  output state_t              state
);

  state_t              next_state;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_empty;
  logic [PACE_W-1:0]   pace_cnt;
  logic [2:0]          tmo_cnt;
  logic                pop;
  logic                launch;
  logic                timeout;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_Async),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_Async) begin
    if (!reset_Async) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (!fifo_empty && pace_cnt == '0) next_state = LAUNCH;
      LAUNCH:     next_state = WAIT_START;
      WAIT_START: begin
        if (trans)                                     next_state = WAIT_DONE;
        else if (tmo_cnt == 3'(TIMEOUT_CYCLES - 1))    next_state = IDLE;
      end
      WAIT_DONE:  if (!trans) next_state = GAP;
      GAP:        next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    launch  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE:       pop     = (next_state == LAUNCH);
      LAUNCH:     launch  = 1'b1;
      WAIT_START: timeout = !trans && (tmo_cnt == 3'(TIMEOUT_CYCLES - 1));
      default:    ;
    endcase
  end

  // go_DAC is registered off the pop so it is high exactly while in LAUNCH.
  always_ff @(posedge clk or negedge reset_Async) begin
    if (!reset_Async) begin
      go_DAC   <= 1'b0;
      DAC_in   <= '0;
      pace_cnt <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      go_DAC <= pop;
      if (pop) DAC_in <= make_frame(CMD, fifo_head);
      if (launch)              pace_cnt <= PACE_W'(DIV - 1);
      else if (pace_cnt != '0) pace_cnt <= pace_cnt - PACE_W'(1);
      tmo_cnt <= (state == WAIT_START) ? tmo_cnt + 3'd1 : 3'd0;
      if (timeout) err <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// Bench for dac_cmd_sequencer: scoreboarded frames, a behavioural serializer
// model, and directed scenarios for latency, pacing, overflow, timeout and reset.
module tb_dac_cmd_sequencer;

  localparam int DIV   = 50;
  localparam int DEPTH = 4;
  localparam int XFER  = 67;
  localparam int SER_NORMAL = 0;
  localparam int SER_HOLD   = 1;
  localparam int SER_SILENT = 2;

  logic        clk;
  logic        reset_Async;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        trans;
  logic        go_DAC;
  logic [27:0] DAC_in;
  logic        busy;
  logic        err;
  dac_pkg::state_t state;

  logic [27:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_go = -1;
  int go_count = 0;
  int min_space = DIV;
  int ser_mode = SER_NORMAL;
  logic prev_go = 1'b0;

  dac_cmd_sequencer #(
    .CMD   (4'b0011),
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_Async (reset_Async),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .trans       (trans),
    .go_DAC      (go_DAC),
    .DAC_in      (DAC_in),
    .busy        (busy),
    .err         (err),
    .state       (state)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [27:0] exp_frame(input logic [15:0] d);
    return {4'h0, 4'h3, d, 4'h0};
  endfunction

  // Must be called at a falling edge; returns one cycle later with wr_en low.
  task automatic drive_write(input logic [15:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(exp_frame(d));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", busy, 1'b0);
  endtask

  // Serializer model: one go_DAC starts an XFER-cycle transfer.
  initial begin
    trans = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_mode == SER_HOLD)        trans = 1'b1;
      else if (ser_mode == SER_SILENT) trans = 1'b0;
      else if (go_DAC) begin
        trans = 1'b1;
        repeat (XFER) @(negedge clk);
        trans = 1'b0;
      end else trans = 1'b0;
    end
  end

  // Scoreboard: every launch must match the oldest expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (go_DAC) begin
        check("go_single_cycle", prev_go, 1'b0);
        check("go_has_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("frame", DAC_in, exp_q.pop_front());
        if (last_go >= 0) check("launch_spacing", (cyc - last_go) >= min_space, 1'b1);
        last_go = cyc;
        go_count++;
      end
      prev_go = go_DAC;
    end
  end

  initial begin
    int gc;
    reset_Async = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_go", go_DAC, 1'b0);
    check("rst_dac_in", DAC_in, 28'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_state", state, dac_pkg::IDLE);
    reset_Async = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: 2-cycle latency, then four back-to-back writes during its transfer.
    drive_write(16'h3ABC, 1'b1);
    check("lat_early_go", go_DAC, 1'b0);
    @(negedge clk);
    check("lat_go", go_DAC, 1'b1);
    check("lat_frame", DAC_in, 28'h033ABC0);
    min_space = XFER + 2;
    drive_write(16'h1111, 1'b1);
    drive_write(16'h2222, 1'b1);
    drive_write(16'h3333, 1'b1);
    check("b2b_not_full", full, 1'b0);
    drive_write(16'h4444, 1'b1);
    check("b2b_full", full, 1'b1);
    wait_drain(1000);
    min_space = DIV;

    // Overflow: a blocker frame is held in transfer while five samples arrive.
    ser_mode = SER_HOLD;
    repeat (2) @(negedge clk);
    drive_write(16'h9000, 1'b1);
    repeat (5) @(negedge clk);
    gc = go_count;
    for (int i = 0; i < 5; i++) drive_write(16'($urandom_range(0, 16'hFFFF)), i < 4);
    check("ovf_full", full, 1'b1);
    repeat (20) @(negedge clk);
    check("ovf_no_launch", go_count, gc);
    ser_mode = SER_NORMAL;
    wait_drain(1000);

    // Timeout: serializer never answers.
    ser_mode = SER_SILENT;
    repeat (2) @(negedge clk);
    check("to_err_before", err, 1'b0);
    drive_write(16'h5A5A, 1'b1);
    @(negedge clk);
    check("to_go", go_DAC, 1'b1);
    repeat (4) @(negedge clk);
    check("to_err_4th", err, 1'b0);
    check("to_busy_4th", busy, 1'b1);
    @(negedge clk);
    check("to_err_5th", err, 1'b1);
    check("to_state_idle", state, dac_pkg::IDLE);

    // Push coinciding with the pop of the only queued entry.
    drive_write(16'h6001, 1'b1);
    repeat (44) @(negedge clk);
    drive_write(16'h6002, 1'b1);
    check("pp_go", go_DAC, 1'b1);
    check("pp_state", state, dac_pkg::LAUNCH);
    drive_write(16'h6003, 1'b1);
    drive_write(16'h6004, 1'b1);
    check("pp_count3_not_full", full, 1'b0);
    drive_write(16'h6005, 1'b1);
    check("pp_count4_full", full, 1'b1);
    repeat (8) @(negedge clk);
    ser_mode = SER_NORMAL;
    wait_drain(1500);
    check("err_sticky", err, 1'b1);

    // Reset in the middle of a transfer with two samples queued.
    drive_write(16'h7001, 1'b1);
    repeat (10) @(negedge clk);
    drive_write(16'h7002, 1'b1);
    drive_write(16'h7003, 1'b1);
    check("mr_pre_state", state, dac_pkg::WAIT_DONE);
    reset_Async = 1'b0;
    #1;
    check("mr_go", go_DAC, 1'b0);
    check("mr_dac_in", DAC_in, 28'h0);
    check("mr_busy", busy, 1'b0);
    check("mr_err", err, 1'b0);
    check("mr_full", full, 1'b0);
    check("mr_state", state, dac_pkg::IDLE);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_Async = 1'b1;
    last_go = -1;
    gc = go_count;
    repeat (80) @(negedge clk);
    check("mr_no_go_after", go_count, gc);
    drive_write(16'h8ACE, 1'b1);
    wait_drain(1000);
    check("mr_new_launch", go_count, gc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_cmd_sequencer.md
DAC_CMD_SEQUENCER -- requirements
Module: dac_cmd_sequencer

Interface
REQ-001 SHALL have parameter CMD, default 4'b0011, the DAC command nibble (write-and-update) placed in every word.
REQ-002 SHALL have parameter DIV, default 50, the minimum number of clk cycles between consecutive go_DAC pulses; legal range 40..65535.
REQ-003 SHALL have parameter DEPTH, default 4, the sample FIFO depth; legal values are powers of two from 2 to 16.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_Async, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1 bit: sample write strobe.
REQ-007 SHALL have port wr_data, input, 16 bits: {addr[3:0], code[11:0]}.
REQ-008 SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-009 SHALL have port trans, input, 1 bit: the downstream SPI serializer's transmitting flag.
REQ-010 SHALL have port go_DAC, output, 1 bit: single-cycle launch pulse to the serializer.
REQ-011 SHALL have port DAC_in, output, 28 bits: the frame presented to the serializer.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-013 SHALL have port err, output, 1 bit: sticky handshake-timeout flag.

Function
REQ-014 SHALL assemble DAC_in as {4'b0000, CMD, addr, code, 4'b0000}, giving cmd at [23:20], addr at [19:16] and code at [15:4].
REQ-015 SHALL accept a write when wr_en=1 and full=0; a write while full is dropped and leaves the FIFO contents unchanged.
REQ-016 SHALL implement the FIFO with wrapping pointers and an occupancy count, so that a simultaneous push and pop leaves the count unchanged.
REQ-017 SHALL use FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE and GAP.
REQ-018 SHALL transition IDLE->LAUNCH when the FIFO is non-empty and the pacing counter is 0; in that cycle it pops the FIFO head into a 28-bit frame register.
REQ-019 SHALL, in LAUNCH, assert go_DAC for exactly one cycle, load the pacing counter with DIV-1, and go to WAIT_START.
REQ-020 SHALL, in WAIT_START, go to WAIT_DONE when trans=1; if trans has not risen within 4 cycles, set err=1 and go to IDLE.
REQ-021 SHALL, in WAIT_DONE, go to GAP when trans=0.
REQ-022 SHALL spend exactly 1 cycle in GAP and then go to IDLE.
REQ-023 SHALL hold DAC_in stable from the LAUNCH cycle until the exit from WAIT_DONE.
REQ-024 SHALL decrement the pacing counter by 1 per cycle while it is non-zero, independent of FSM state.
REQ-025 SHALL produce go_DAC pulses at least DIV cycles apart (launch-to-launch).
REQ-026 SHALL give a latency of 2 cycles from a write into an empty FIFO, with the FSM idle and the pacing counter at 0, to the go_DAC pulse.
REQ-027 SHALL leave err set until reset; err does not block further launches.
REQ-028 SHALL ignore trans while in IDLE or GAP.

Reset
REQ-029 SHALL, on reset_Async=0 and asynchronously, force: FSM=IDLE, FIFO empty, pacing counter=0, go_DAC=0, DAC_in=0, busy=0, err=0, full=0.
REQ-030 SHALL, on reset mid-transfer, discard the in-flight frame and all queued samples; no go_DAC pulse occurs until after the reset is released.
REQ-031 SHALL register all outputs, except that full and busy may be decoded directly from registers.

Structure
REQ-032 SHALL take the FSM state encoding, the frame field offsets and the default CMD from the shared package dac_pkg.
REQ-033 SHALL instantiate one sub-module, sample_fifo (parameterised by width and depth), for the FIFO; the pacing counter and FSM stay in the top module.

Verification
REQ-034 SHALL cover a single-sample frame: write 16'h3ABC to an idle block -> go_DAC pulses 2 cycles later with DAC_in=28'h033ABC0.
REQ-035 SHALL cover back-to-back samples: 4 writes in consecutive cycles, with trans modelled as a 67-cycle transfer -> 4 frames are launched in order, full=1 after the 4th write, and pulse spacing is >= max(DIV, transfer time + 2).
REQ-036 SHALL cover overflow: 5 writes with no launches permitted (trans held high) -> the 5th write is dropped, and the first 4 samples later emerge unchanged.
REQ-037 SHALL cover timeout: trans held at 0 after go_DAC -> err=1 at the 5th cycle after LAUNCH, the FSM returns to IDLE, and the next sample still launches.
REQ-038 SHALL cover mid-transfer reset: reset_Async=0 during WAIT_DONE with 2 samples queued -> all outputs are 0 immediately; after release, no go_DAC occurs until a new write.
REQ-039 SHALL cover a simultaneous push and pop: a write in the same cycle as an IDLE->LAUNCH pop with 1 entry queued -> the count stays 1 and the new sample becomes the next frame.
